// File: rtl/gray_ctrl_pkg.sv
// Shared types and helpers for the Gray-code counter sequencer.
package gray_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2,
      DONE = 2'd3
   } state_e;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   localparam int MAX_W = 32;

   // Binary-to-Gray conversion of the low 'width' bits; bits above 'width' are cleared.
   function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] bin,
                                                 input int unsigned      width);
      logic [MAX_W-1:0] mask;
      if (width >= MAX_W) mask = '1;
      else                mask = (MAX_W'(1) << width) - MAX_W'(1);
      return (bin ^ (bin >> 1)) & mask;
   endfunction

endpackage

// File: rtl/gray_updown_core.sv
// Binary up/down counter (natural wrap over 2**W) with registered Gray-code output.
module gray_updown_core
   import gray_ctrl_pkg::*;
#(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         dir,
   output logic [W-1:0] gray_out
);

   logic [W-1:0] bin_q, bin_d;
   logic [W-1:0] gray_q, gray_d;

   always_comb begin
      bin_d = bin_q;
      if (en) begin
         if (dir == DIR_UP) bin_d = bin_q + W'(1);
         else               bin_d = bin_q - W'(1);
      end
      gray_d = W'(bin2gray(MAX_W'(bin_d), W));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bin_q  <= '0;
         gray_q <= '0;
      end else begin
         bin_q  <= bin_d;
         gray_q <= gray_d;
      end
   end

   assign gray_out = gray_q;

endmodule

// File: rtl/gray_counter_ctrl.sv
// Command-driven sequencer stepping a Gray counter N positions with pause/abort.
// Optional adjacency checker compiled in when GRAY_CTRL_CHECK_EN is defined.
module gray_counter_ctrl
   import gray_ctrl_pkg::*;
#(
   parameter int MOD_VALUE = 8,
   parameter int STEP_W    = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic                         cmd_dir,
   input  logic [STEP_W-1:0]            cmd_steps,
   input  logic                         pause,
   input  logic                         abort,
   output logic [$clog2(MOD_VALUE)-1:0] gray_out,
   output logic [STEP_W-1:0]            steps_left,
   output logic                         busy,
   output logic                         done,
   output logic                         err
);

   localparam int W = $clog2(MOD_VALUE);

   state_e              state_q, state_d;
   logic [STEP_W-1:0]   steps_q, steps_d;
   logic                dir_q, dir_d;
   logic                accept;
   logic                active;
   logic                advance;

   assign accept  = cmd_valid & cmd_ready;
   assign active  = (state_q == RUN) || (state_q == HOLD);
   // Abort outranks both pause and the final step.
   assign advance = active & ~pause & ~abort;

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) state_d = (cmd_steps == '0) ? DONE : RUN;
         end
         RUN, HOLD: begin
            if (abort)                           state_d = DONE;
            else if (pause)                      state_d = HOLD;
            else if (steps_q == STEP_W'(1))      state_d = DONE;
            else                                 state_d = RUN;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = (state_q == IDLE) & ~rst;
      busy      = active;
      done      = (state_q == DONE);
   end

   always_comb begin
      steps_d = steps_q;
      dir_d   = dir_q;
      if (accept) begin
         steps_d = cmd_steps;
         dir_d   = cmd_dir;
      end else if (advance) begin
         steps_d = steps_q - STEP_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) steps_q <= '0;
      else     steps_q <= steps_d;
      dir_q <= dir_d;
   end

   assign steps_left = steps_q;

   gray_updown_core #(.W(W)) u_core (
      .clk      (clk),
      .rst      (rst),
      .en       (advance),
      .dir      (dir_q),
      .gray_out (gray_out)
   );

`ifdef GRAY_CTRL_CHECK_EN
   logic [W-1:0] prev_gray_q;
   logic         adv_q;
   logic         err_q, err_d;

   // The new Gray value lands one cycle after the advance, so compare then.
   always_comb begin
      err_d = err_q;
      if (adv_q && ($countones(prev_gray_q ^ gray_out) != 1)) err_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
         adv_q <= 1'b0;
      end else begin
         err_q <= err_d;
         adv_q <= advance;
      end
      prev_gray_q <= gray_out;
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_counter_ctrl.sv
// Directed bench for gray_counter_ctrl with an integer position model checked every cycle.
module tb_gray_counter_ctrl;

   localparam int MOD    = 8;
   localparam int STEP_W = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic              cmd_dir = 1'b0;
   logic [STEP_W-1:0] cmd_steps = '0;
   logic              pause = 1'b0;
   logic              abort = 1'b0;
   logic [2:0]        gray_out;
   logic [STEP_W-1:0] steps_left;
   logic              busy, done, err;

   int n_checks = 0;
   int n_pass   = 0;

   gray_counter_ctrl #(.MOD_VALUE(MOD), .STEP_W(STEP_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_dir    (cmd_dir),
      .cmd_steps  (cmd_steps),
      .pause      (pause),
      .abort      (abort),
      .gray_out   (gray_out),
      .steps_left (steps_left),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
   endtask

   // Model: integer position, remaining count, and whether a command is live.
   int m_pos = 0, m_rem = 0;
   bit m_active = 0, m_done = 0, m_dir = 0, m_en = 0;

   always @(posedge clk) begin
      if (rst) begin
         m_pos = 0; m_rem = 0; m_active = 0; m_done = 0; m_en = 1;
      end else begin
         bit fin;
         fin = 0;
         if (!m_active && !m_done && cmd_valid) begin
            m_dir = cmd_dir;
            m_rem = int'(cmd_steps);
            if (m_rem == 0) fin = 1;
            else            m_active = 1;
         end else if (m_active) begin
            if (abort) begin
               m_active = 0; fin = 1;
            end else if (!pause) begin
               m_pos = m_dir ? (m_pos + 1) % MOD : (m_pos + MOD - 1) % MOD;
               m_rem = m_rem - 1;
               if (m_rem == 0) begin m_active = 0; fin = 1; end
            end
         end
         m_done = fin;
      end
   end

   always @(negedge clk) begin
      if (m_en) begin
         chk("model gray_out",   int'(gray_out),   m_pos ^ (m_pos >> 1));
         chk("model steps_left", int'(steps_left), m_rem);
         chk("model busy",       int'(busy),       int'(m_active));
         chk("model done",       int'(done),       int'(m_done));
         chk("model cmd_ready",  int'(cmd_ready),  int'(!m_active && !m_done && !rst));
         chk("model err",        int'(err),        0);
      end
   end

   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   task automatic issue(input logic d, input int n);
      cmd_valid = 1'b1; cmd_dir = d; cmd_steps = STEP_W'(n);
      cyc();
      cmd_valid = 1'b0;
   endtask

   int exp_up5 [5] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111};

   initial begin
      // Reset
      rst = 1'b1;
      cyc(); cyc();
      chk("rst gray_out", int'(gray_out), 0);
      chk("rst steps_left", int'(steps_left), 0);
      chk("rst cmd_ready", int'(cmd_ready), 0);
      chk("rst busy/done", int'({busy, done}), 0);
      rst = 1'b0;
      cyc();
      chk("idle cmd_ready", int'(cmd_ready), 1);

      // Up 5 from 0
      issue(1'b1, 5);
      chk("up5 accept busy", int'(busy), 1);
      chk("up5 accept steps", int'(steps_left), 5);
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("up5 gray", int'(gray_out), exp_up5[i]);
         chk("up5 steps", int'(steps_left), 4 - i);
      end
      chk("up5 done", int'(done), 1);
      chk("up5 ready during done", int'(cmd_ready), 0);
      cyc();
      chk("up5 done cleared", int'(done), 0);
      chk("up5 ready back", int'(cmd_ready), 1);

      // Move to bin 7 (gray 100), then wrap up
      issue(1'b1, 2);
      cyc(); cyc(); cyc();
      chk("pre-wrap gray", int'(gray_out), 3'b100);
      issue(1'b1, 2);
      cyc();
      chk("wrap up gray0", int'(gray_out), 3'b000);
      cyc();
      chk("wrap up gray1", int'(gray_out), 3'b001);
      cyc();

      // Back to 0, then wrap down
      issue(1'b0, 1);
      cyc(); cyc();
      chk("pre-down gray", int'(gray_out), 3'b000);
      issue(1'b0, 3);
      cyc(); chk("down gray0", int'(gray_out), 3'b100);
      cyc(); chk("down gray1", int'(gray_out), 3'b101);
      cyc(); chk("down gray2", int'(gray_out), 3'b111);
      chk("down done", int'(done), 1);
      cyc();

      // Up 4 from bin 5 with a 3-cycle pause after the 2nd advance
      issue(1'b1, 4);
      cyc(); cyc();
      chk("pause pre gray", int'(gray_out), 3'b100);
      pause = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("pause hold gray", int'(gray_out), 3'b100);
         chk("pause hold steps", int'(steps_left), 2);
         chk("pause no done", int'(done), 0);
      end
      pause = 1'b0;
      cyc(); chk("pause resume gray", int'(gray_out), 3'b000);
      chk("pause resume no done", int'(done), 0);
      cyc(); chk("pause last gray", int'(gray_out), 3'b001);
      chk("pause late done", int'(done), 1);
      cyc();

      // Up 6 from bin 1, abort (with pause) after 2 advances
      issue(1'b1, 6);
      cyc(); cyc();
      chk("abort pre gray", int'(gray_out), 3'b010);
      abort = 1'b1; pause = 1'b1;
      cyc();
      chk("abort done", int'(done), 1);
      chk("abort steps frozen", int'(steps_left), 4);
      chk("abort gray held", int'(gray_out), 3'b010);
      abort = 1'b0; pause = 1'b0;
      cyc();
      chk("abort ready back", int'(cmd_ready), 1);

      // Zero-step command; second command held through DONE
      cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = '0;
      cyc();
      cmd_steps = STEP_W'(3);
      chk("zero done", int'(done), 1);
      chk("zero gray unchanged", int'(gray_out), 3'b010);
      chk("zero not ready in done", int'(cmd_ready), 0);
      cyc();
      chk("held cmd not taken", int'(busy), 0);
      cyc();
      cmd_valid = 1'b0;
      chk("held cmd taken", int'(busy), 1);
      chk("held cmd steps", int'(steps_left), 3);
      cyc();
      chk("held cmd gray", int'(gray_out), 3'b110);

      // Reset mid-run
      rst = 1'b1;
      cyc();
      chk("midrst gray", int'(gray_out), 0);
      chk("midrst busy", int'(busy), 0);
      chk("midrst ready", int'(cmd_ready), 0);
      rst = 1'b0;
      cyc();
      chk("midrst no done", int'(done), 0);
      chk("midrst ready back", int'(cmd_ready), 1);
      cyc();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/gray_counter_ctrl.md
# gray_counter_ctrl

Command-driven sequencer for an up/down Gray-code counter. It accepts "step N positions in direction D" commands over a valid/ready handshake and advances the counter one Gray position per enabled cycle. It supports pause and abort, and reports completion with a single-cycle done pulse. It sits between a control master (test sequencer, FIFO pointer manager, position tracker) and the Gray counting datapath.

## Interface
- MOD_VALUE, 8, counter modulus; power of two, ≥2; W = $clog2(MOD_VALUE)
- STEP_W, 8, width of step-count field
- clk  in  1  clock, rising edge
- rst  in  1  reset; **one clock; reset is synchronous and active-high**
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_dir  in  1  1 = up, 0 = down
- cmd_steps  in  STEP_W  number of positions to advance
- pause  in  1  level; holds the count while high
- abort  in  1  level; terminates the active command
- gray_out  out  W  current Gray position (registered)
- steps_left  out  STEP_W  remaining steps of the active command
- busy  out  1  state is RUN or HOLD
- done  out  1  one-cycle completion pulse
- err  out  1  sticky Gray-adjacency error (see Configuration)

## Operation
- States: IDLE, RUN, HOLD, DONE.
- cmd_ready = (state==IDLE) & ~rst, combinational. No other state accepts commands; cmd_valid outside IDLE is ignored, not queued.
- IDLE, on accept:
  - latch dir; steps_left ← cmd_steps.
  - cmd_steps==0 → DONE, no count change.
  - otherwise → RUN.
- Advance condition: (RUN or HOLD) & ~pause & ~abort.
  - On advance, the internal binary count moves ±1 mod MOD_VALUE, gray_out ← bin ^ (bin>>1), and steps_left decrements.
  - Advance with steps_left==1 → DONE.
- RUN/HOLD with pause=1 & abort=0 → HOLD; no advance.
- HOLD with pause=0 & abort=0 advances that cycle and returns to RUN. A pause of P cycles delays completion by exactly P cycles.
- abort=1 in RUN/HOLD → DONE; no advance; steps_left frozen at its remaining value.
  - Abort has priority over pause and over the final step.
  - Abort in IDLE/DONE is ignored.
- DONE: done=1 for exactly one cycle, then → IDLE.
- Wrap-around:
  - Up from bin MOD_VALUE-1 goes to 0 (W=3: gray 100→000).
  - Down from 0 goes to MOD_VALUE-1 (000→100).
- gray_out persists across commands. Only rst returns it to 0.
- Reset mid-command: everything returns to the reset state, no done pulse, and the command is lost.

## Timing
- Reset values: state IDLE, gray_out 0, steps_left 0, busy 0, done 0, err 0; cmd_ready 0 while rst=1.
- Accept at edge E0 → state RUN from E0; the first advance is visible after edge E1.
- The Nth advance is at edge E_N, which also enters DONE. done is high in cycle E_N..E_N+1, and cmd_ready returns at E_N+1.
- Command turnaround is N+2 cycles with no pause (zero-step command: 2 cycles).
- Exactly one bit of gray_out changes per advance; gray_out never changes on a non-advance cycle.

## Configuration
- GRAY_CTRL_CHECK_EN defined:
  - The previous gray_out is registered.
  - On each advance, if popcount(prev ^ new) ≠ 1, err is set. err is sticky until rst.
- Undefined: no checker logic is compiled in, and err is tied to 0. The port exists in both builds.

## Structure
- Package gray_ctrl_pkg holds:
  - the state enum typedef (IDLE/RUN/HOLD/DONE)
  - a bin2gray function parameterised by width
  - direction constants DIR_UP=1 and DIR_DOWN=0
- Sub-module gray_updown_core (clk, rst, en, dir → gray_out) holds the binary up/down counter plus the Gray conversion. gray_counter_ctrl holds the FSM, step counter, handshake and optional checker.

## Test plan
All scenarios use MOD_VALUE=8 and run with GRAY_CTRL_CHECK_EN defined; err must stay 0 throughout.
- Reset, then cmd up, 5 steps → gray_out 001,011,010,110,111 on E1..E5; steps_left 4..0; done high one cycle after E5; cmd_ready at E6.
- Starting at gray 100 (bin 7), cmd up, 2 steps → 000, then 001 (wrap).
- Starting at 000, cmd down, 3 steps → 100, 101, 111.
- Up, 4 steps, with pause high for 3 cycles after the 2nd advance → gray_out and steps_left hold for 3 cycles; done arrives 3 cycles later than the unpaused run.
- Up, 6 steps, abort asserted after 2 advances (with pause also high) → no further advance, done next cycle, steps_left=4.
- cmd_steps=0 → done 1 cycle after accept, gray_out unchanged; a second cmd_valid held during DONE is not accepted until IDLE; rst asserted mid-RUN → gray_out 0, no done.
